// File: rtl/conv_pkg.sv
// Shared types and arithmetic helpers for the convolution and pooling stages.
package conv_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    CALC,
    HOLD,
    LOAD,
    FLUSH
  } state_t;

  function automatic int acc_width(input int dw, input int d, input int f);
    return 2 * dw + $clog2(d * f * f);
  endfunction

  // Arithmetic shift, then clamp to the signed range of a dw-bit value.
  function automatic logic signed [63:0] sat_shift(
    input logic signed [63:0] acc,
    input int                 dw,
    input int                 sh
  );
    logic signed [63:0] v;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    v  = acc >>> sh;
    hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (dw - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/conv_row_mac.sv
// One filter over the padded line buffer: W saturated outputs per row.
// CONV_RELU_EN clamps negative results to zero.
module conv_row_mac
  import conv_pkg::*;
#(
  parameter int DW    = 8,
  parameter int D     = 1,
  parameter int W     = 6,
  parameter int F     = 3,
  parameter int SHIFT = 4
) (
  input  logic [F*(W+2*(F/2))*D*DW-1:0] rows,
  input  logic [D*F*F*DW-1:0]           weights,
  output logic [W*DW-1:0]               result
);

  localparam int P     = F / 2;
  localparam int WP    = W + 2 * P;
  localparam int ACC_W = acc_width(DW, D, F);

  logic signed [ACC_W-1:0] acc;
  logic signed [2*DW-1:0]  prod;
  logic signed [63:0]      sat;

  always_comb begin
    result = '0;
    acc    = '0;
    prod   = '0;
    sat    = '0;
    for (int x = 0; x < W; x++) begin
      acc = '0;
      for (int c = 0; c < D; c++) begin
        for (int r = 0; r < F; r++) begin
          for (int s = 0; s < F; s++) begin
            prod = $signed(rows[((r*WP+x+s)*D+c)*DW +: DW])
                 * $signed(weights[((c*F+r)*F+s)*DW +: DW]);
            acc  = acc + ACC_W'(prod);
          end
        end
      end
      sat = sat_shift(64'(acc), DW, SHIFT);
`ifdef CONV_RELU_EN
      if (sat < 0) sat = '0;
`endif
      result[x*DW +: DW] = sat[DW-1:0];
    end
  end

endmodule

// File: rtl/conv_layer_stream.sv
// Streaming K-filter 2-D convolution with an F-row line buffer.
// Optional CONV_RELU_EN zeroes negative outputs.
module conv_layer_stream
  import conv_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int D          = 1,
  parameter int H          = 6,
  parameter int W          = 6,
  parameter int F          = 3,
  parameter int K          = 64,
  parameter int SHIFT      = 4
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [K*D*F*F*DATA_WIDTH-1:0]   filters,
  input  logic [W*D*DATA_WIDTH-1:0]       in_data,
  input  logic                            in_first,
  input  logic                            in_valid,
  output logic                            in_ready,
  output logic [W*K*DATA_WIDTH-1:0]       out_data,
  output logic                            out_last,
  output logic                            out_valid,
  input  logic                            out_ready
);

  localparam int DW     = DATA_WIDTH;
  localparam int P      = F / 2;
  localparam int RW     = W * D * DW;
  localparam int PRW    = (W + 2 * P) * D * DW;
  localparam int KW     = D * F * F * DW;
  localparam int FILL_N = (P + 1 < H) ? P + 1 : H;
  // Short frames hold fewer rows than P+1; skew taps so row 0 stays centred.
  localparam int OFF    = P + 1 - FILL_N;
  localparam int CW     = $clog2(H + 1);

  localparam logic [CW-1:0] H_C    = CW'(H);
  localparam logic [CW-1:0] H_M1   = CW'(H - 1);
  localparam logic [CW-1:0] FILL_C = CW'(FILL_N);

  state_t          state;
  logic [CW-1:0]   n_in;
  logic [CW-1:0]   n_out;
  logic [RW-1:0]   lb [F];
  logic [F*PRW-1:0] pad;
  logic [W*K*DW-1:0] mac_out;
  logic            hs_in;
  logic            first;

  assign in_ready = !reset &&
    (state == IDLE || state == FILL || state == LOAD);
  assign out_valid = (state == HOLD);
  assign hs_in     = in_valid && in_ready;
  assign first     = hs_in && in_first;

  for (genvar r = 0; r < F; r++) begin : g_pad
    if (r + OFF < F) begin : g_row
      assign pad[r*PRW +: PRW] = PRW'(lb[r+OFF]) << (P * D * DW);
    end else begin : g_zero
      assign pad[r*PRW +: PRW] = '0;
    end
  end

  for (genvar k = 0; k < K; k++) begin : g_mac
    conv_row_mac #(
      .DW    (DW),
      .D     (D),
      .W     (W),
      .F     (F),
      .SHIFT (SHIFT)
    ) u_mac (
      .rows    (pad),
      .weights (filters[k*KW +: KW]),
      .result  (mac_out[k*W*DW +: W*DW])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      n_in     <= '0;
      n_out    <= '0;
      out_data <= '0;
      out_last <= 1'b0;
    end else if (first) begin
      // A frame start always clears the buffer, aborting any frame in flight.
      for (int i = 0; i < F; i++) lb[i] <= '0;
      lb[F-1] <= in_data;
      n_in    <= CW'(1);
      n_out   <= '0;
      state   <= (FILL_N == 1) ? CALC : FILL;
    end else begin
      unique case (state)
        IDLE: ;
        FILL: begin
          if (hs_in) begin
            for (int i = 0; i < F - 1; i++) lb[i] <= lb[i+1];
            lb[F-1] <= in_data;
            n_in    <= n_in + CW'(1);
            if (n_in + CW'(1) == FILL_C) state <= CALC;
          end
        end
        CALC: begin
          out_data <= mac_out;
          out_last <= (n_out == H_M1);
          state    <= HOLD;
        end
        HOLD: begin
          if (out_ready) begin
            n_out <= n_out + CW'(1);
            if (out_last)         state <= IDLE;
            else if (n_in < H_C)  state <= LOAD;
            else                  state <= FLUSH;
          end
        end
        LOAD: begin
          if (hs_in) begin
            for (int i = 0; i < F - 1; i++) lb[i] <= lb[i+1];
            lb[F-1] <= in_data;
            n_in    <= n_in + CW'(1);
            state   <= CALC;
          end
        end
        FLUSH: begin
          for (int i = 0; i < F - 1; i++) lb[i] <= lb[i+1];
          lb[F-1] <= '0;
          state   <= CALC;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_layer_stream.sv
// Directed bench: 6x6 two-filter instance plus a single-row instance.
module tb_conv_layer_stream;

  logic         clk = 1'b0;
  logic         reset;
  logic [143:0] filters_a;
  logic [47:0]  in_data_a;
  logic         in_first_a, in_valid_a, in_ready_a;
  logic [95:0]  out_data_a;
  logic         out_last_a, out_valid_a, out_ready_a;

  logic [71:0]  filters_b;
  logic [47:0]  in_data_b;
  logic         in_first_b, in_valid_b, in_ready_b;
  logic [47:0]  out_data_b;
  logic         out_last_b, out_valid_b, out_ready_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  conv_layer_stream #(
    .DATA_WIDTH(8), .D(1), .H(6), .W(6), .F(3), .K(2), .SHIFT(0)
  ) dut_a (
    .clk(clk), .reset(reset), .filters(filters_a),
    .in_data(in_data_a), .in_first(in_first_a),
    .in_valid(in_valid_a), .in_ready(in_ready_a),
    .out_data(out_data_a), .out_last(out_last_a),
    .out_valid(out_valid_a), .out_ready(out_ready_a)
  );

  conv_layer_stream #(
    .DATA_WIDTH(8), .D(1), .H(1), .W(6), .F(3), .K(1), .SHIFT(4)
  ) dut_b (
    .clk(clk), .reset(reset), .filters(filters_b),
    .in_data(in_data_b), .in_first(in_first_b),
    .in_valid(in_valid_b), .in_ready(in_ready_b),
    .out_data(out_data_b), .out_last(out_last_b),
    .out_valid(out_valid_b), .out_ready(out_ready_b)
  );

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // mode 0: all-ones image, f0 all ones, f1 centre weight 2.
  // mode 1: pixels 127, f0 all 127, f1 all -127.
  function automatic logic [95:0] exp_a(input int mode, input int y);
    logic [95:0] r;
    int nr, nc;
    r = '0;
    for (int x = 0; x < 6; x++) begin
      if (mode == 0) begin
        nr = (y == 0 || y == 5) ? 2 : 3;
        nc = (x == 0 || x == 5) ? 2 : 3;
        r[x*8 +: 8]     = 8'(nr * nc);
        r[(6+x)*8 +: 8] = 8'd2;
      end else begin
        r[x*8 +: 8] = 8'd127;
`ifdef CONV_RELU_EN
        r[(6+x)*8 +: 8] = 8'd0;
`else
        r[(6+x)*8 +: 8] = 8'h80;
`endif
      end
    end
    return r;
  endfunction

  task automatic send(input logic [47:0] row, input logic fst);
    int n;
    in_data_a  = row;
    in_first_a = fst;
    in_valid_a = 1'b1;
    n = 0;
    while (!in_ready_a && n < 40) begin
      step();
      n++;
    end
    chk("send_ready", in_ready_a, 1'b1);
    step();
    in_valid_a = 1'b0;
    in_first_a = 1'b0;
  endtask

  task automatic get(input int mode, input int y);
    int n;
    n = 0;
    while (!out_valid_a && n < 40) begin
      step();
      n++;
    end
    chk($sformatf("row%0d_valid", y), out_valid_a, 1'b1);
    chk($sformatf("row%0d_data", y), out_data_a, exp_a(mode, y));
    chk($sformatf("row%0d_last", y), out_last_a, y == 5);
    out_ready_a = 1'b1;
    step();
    out_ready_a = 1'b0;
  endtask

  task automatic head(input logic [47:0] row);
    send(row, 1'b1);
    send(row, 1'b0);
    chk("lat_early", out_valid_a, 1'b0);
    step();
    chk("lat_rise", out_valid_a, 1'b1);
  endtask

  task automatic tail(input int mode, input logic [47:0] row);
    for (int y = 1; y < 5; y++) begin
      send(row, 1'b0);
      get(mode, y);
    end
    get(mode, 5);
    chk("idle_ready", in_ready_a, 1'b1);
    chk("idle_valid", out_valid_a, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    logic [47:0] ones;
    logic [47:0] p127;
    logic [71:0] f1;
    ones = {6{8'd1}};
    p127 = {6{8'd127}};
    f1 = '0;
    f1[4*8 +: 8] = 8'd2;
    filters_a   = {f1, {9{8'd1}}};
    filters_b   = {9{8'd1}};
    in_data_a   = '0;
    in_data_b   = {6{8'd16}};
    in_first_a  = 1'b0;
    in_valid_a  = 1'b0;
    out_ready_a = 1'b0;
    in_first_b  = 1'b0;
    in_valid_b  = 1'b0;
    out_ready_b = 1'b0;
    reset       = 1'b1;
    step();
    step();
    chk("rst_in_ready", in_ready_a, 1'b0);
    chk("rst_out_valid", out_valid_a, 1'b0);
    chk("rst_out_data", out_data_a, 96'h0);
    chk("rst_out_last", out_last_a, 1'b0);
    reset = 1'b0;
    step();

    // Frame with a 5-cycle output stall on row 0.
    head(ones);
    for (int i = 0; i < 5; i++) begin
      in_data_a  = ones;
      in_valid_a = 1'b1;
      step();
      chk("stall_data", out_data_a, exp_a(0, 0));
      chk("stall_last", out_last_a, 1'b0);
      chk("stall_ready", in_ready_a, 1'b0);
      chk("stall_valid", out_valid_a, 1'b1);
    end
    in_valid_a = 1'b0;
    get(0, 0);
    tail(0, ones);

    // Row without in_first while idle is dropped.
    send(p127, 1'b0);
    for (int i = 0; i < 4; i++) step();
    chk("drop_valid", out_valid_a, 1'b0);
    chk("drop_ready", in_ready_a, 1'b1);

    // Restart on row 3 of a frame.
    head(ones);
    get(0, 0);
    send(ones, 1'b0);
    get(0, 1);
    send(ones, 1'b1);
    chk("restart_nov", out_valid_a, 1'b0);
    send(ones, 1'b0);
    chk("restart_lat0", out_valid_a, 1'b0);
    step();
    chk("restart_lat1", out_valid_a, 1'b1);
    get(0, 0);
    tail(0, ones);

    // Reset while holding an output.
    head(ones);
    reset = 1'b1;
    step();
    chk("rst_hold_valid", out_valid_a, 1'b0);
    chk("rst_hold_ready", in_ready_a, 1'b0);
    reset = 1'b0;
    step();
    head(ones);
    get(0, 0);
    tail(0, ones);

    // Saturation in both directions.
    filters_a = {{9{8'h81}}, {9{8'd127}}};
    head(p127);
    get(1, 0);
    tail(1, p127);

    // Single-row frame with SHIFT=4.
    in_valid_b = 1'b1;
    in_first_b = 1'b1;
    chk("b_ready", in_ready_b, 1'b1);
    step();
    in_valid_b = 1'b0;
    in_first_b = 1'b0;
    chk("b_lat0", out_valid_b, 1'b0);
    step();
    chk("b_lat1", out_valid_b, 1'b1);
    chk("b_data", out_data_b, 48'h02_03_03_03_03_02);
    chk("b_last", out_last_b, 1'b1);
    out_ready_b = 1'b1;
    step();
    out_ready_b = 1'b0;
    chk("b_idle_valid", out_valid_b, 1'b0);
    chk("b_idle_ready", in_ready_b, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/conv_layer_stream.md
# conv_layer_stream

Streaming multi-channel, multi-filter 2-D convolution layer. It accepts an image one row at a time over a valid/ready handshake and keeps an F-row line buffer. Zero padding is inserted internally on all four borders. For each input position it emits one full output row for all K filters, with rounding-free arithmetic shift and saturation back to DATA_WIDTH. It sits between the row fetcher and the pooling stage, and replaces the fixed three-row, single-channel layer.

## Interface
- DATA_WIDTH, 8: signed pixel/weight width
- D, 1: input channels
- H, 6: image height (rows per frame)
- W, 6: image width
- F, 3: filter size, odd, F >= 1
- K, 64: number of filters
- SHIFT, 4: arithmetic right shift applied to accumulator before saturation
- clk  in  1  clock; everything sampled on rising edge
- reset  in  1  synchronous, active-high
- filters  in  K*D*F*F*DATA_WIDTH  weights, filter-major, then channel, row, column; must be stable for the whole frame
- in_data  in  W*D*DATA_WIDTH  one unpadded input row, pixel-major, channel-minor
- in_first  in  1  marks row 0 of a frame; qualified by in_valid
- in_valid  in  1  row available
- in_ready  out  1  row accepted when in_valid && in_ready
- out_data  out  W*K*DATA_WIDTH  one output row, filter-major, then pixel
- out_last  out  1  output row H-1
- out_valid  out  1  output row available
- out_ready  in  1  output row consumed when out_valid && out_ready

## Operation
- P = F/2. Output row y uses input rows y-P..y+P. Rows outside 0..H-1 and columns outside 0..W-1 read as zero.
- Line buffer: F rows. Each load shifts it up by one and writes the new row (input, or zero when flushing) at the bottom.
- States:
  - IDLE: in_ready=1; only a row with in_first is accepted and becomes row 0; rows without in_first are accepted and dropped. Go to FILL, or to CALC if H==1 or P==0.
  - FILL: in_ready=1; load rows until min(P+1, H) rows are held, then CALC.
  - CALC: one cycle; compute all W*K outputs, register them into out_data, then HOLD.
  - HOLD: out_valid=1 until out_ready; on the handshake:
    - last output row → IDLE;
    - input rows remaining → LOAD;
    - otherwise → FLUSH.
  - LOAD: in_ready=1; accept one row, then CALC.
  - FLUSH: shift one zero row in (one cycle, in_ready=0), then CALC.
- Restart: in_first accepted in FILL or LOAD aborts the current frame. The buffer is cleared to zero, the row is taken as row 0, and the state continues as if from IDLE. The pending output is not emitted.
- Arithmetic:
  - Products are 2*DATA_WIDTH signed.
  - Accumulator width ACC_W = 2*DATA_WIDTH + clog2(D*F*F).
  - Result = acc >>> SHIFT, saturated to [-2^(DW-1), 2^(DW-1)-1].
- out_last = 1 with output row H-1.

## Timing
- Reset values:
  - state IDLE
  - out_valid 0, out_last 0, out_data 0
  - in_ready 0 while reset is high
- in_ready and out_valid are decoded from the registered state. There is no combinational path from in_valid/out_ready to the outputs.
- First output: out_valid rises 2 cycles after the handshake of row min(P, H-1).
- Steady state: one output row per 3 cycles with in_valid and out_ready held high (LOAD, CALC, HOLD).
- out_data and out_last are held stable while out_valid && !out_ready.
- Reset mid-frame discards everything and returns to IDLE on the next cycle.

## Configuration
- CONV_RELU_EN defined: saturated results below zero output 0, giving output range [0, 2^(DW-1)-1].
- Not defined: signed saturated result passes through unchanged.

## Structure
- Package conv_pkg holds:
  - state enum (IDLE, FILL, CALC, HOLD, LOAD, FLUSH);
  - function acc_width(DW, D, F);
  - saturate/shift function shared with the pooling stage.
- Sub-module conv_row_mac: one filter, D*F*F window over the F×(W+2P) padded buffer, producing W saturated outputs; instantiated K times by generate.
- Top contains line buffer, row counters (input rows received, output rows emitted) and the FSM.

## Test plan
- All-ones 6×6 image, D=1, K=1, all-ones 3×3 filter, SHIFT=0 → row 0 = 4,6,6,6,6,4; rows 1-4 = 6,9,9,9,9,6; row 5 = row 0; out_last only on row 5.
- Pixels 127, weights 127, SHIFT=0 → every output 127. With weights -127 → -128, or 0 with CONV_RELU_EN.
- out_ready held low 5 cycles after first out_valid → out_data and out_last unchanged, in_ready=0 throughout; the next row is accepted only after the handshake.
- in_first asserted again on row 3 → no further outputs from the old frame; the new frame's 6 rows are correct, and the first out_valid comes 2 cycles after the new row-1 handshake.
- Reset pulsed in HOLD → out_valid 0 next cycle; a following full frame matches the first scenario.
- H=1, F=3 → a single output row from zero/row0/zero, out_last=1, then IDLE.
